serv_dbus_responder: RTL and testbench



---
 rtl/serv_dbus_pkg.sv | 27 ++
 rtl/serv_dbus_timer.sv | 47 ++++
 rtl/serv_dbus_responder.sv | 112 +++++++++++
 tb/tb_serv_dbus_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_dbus_pkg.sv
// Shared types and constants for the SERV data-bus responder:
// FSM states, timer register offsets and the byte-lane merge helper.
package serv_dbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [2:0]  MTIME_OFS    = 3'd0;
   localparam logic [2:0]  MTIMECMP_OFS = 3'd4;
   localparam int          REGION_BIT   = 31;
   localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/serv_dbus_timer.sv
// Machine timer: prescaled 32-bit mtime, mtimecmp, byte-lane write port,
// read mux and a registered mtime >= mtimecmp interrupt.
module serv_dbus_timer
   import serv_dbus_pkg::*;
#(
   parameter int TIMER_DIV = 1
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_we,
   input  logic        i_cmp_sel,
   input  logic [3:0]  i_sel,
   input  logic [31:0] i_dat,
   output logic [31:0] o_rdt,
   output logic        o_irq
);

   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

   logic [PW-1:0] presc;
   logic          tick;
   logic [31:0]   mtime;
   logic [31:0]   mtimecmp;

   assign tick = (presc == PW'(TIMER_DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc    <= '0;
         mtime    <= '0;
         mtimecmp <= MTIMECMP_RST;
         o_irq    <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         // A bus write to mtime overrides a coincident increment.
         if (i_we && !i_cmp_sel) mtime <= byte_merge(mtime, i_dat, i_sel);
         else if (tick)          mtime <= mtime + 32'd1;
         if (i_we && i_cmp_sel)  mtimecmp <= byte_merge(mtimecmp, i_dat, i_sel);
         o_irq <= (mtime >= mtimecmp);
      end
   end

   assign o_rdt = i_cmp_sel ? mtimecmp : mtime;

endmodule

// File: rtl/serv_dbus_responder.sv
// Wishbone classic responder for SERV's data bus: word RAM with byte lanes
// plus the machine timer, with a programmable number of wait states.
module serv_dbus_responder
   import serv_dbus_pkg::*;
#(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 1,
   parameter int TIMER_DIV   = 1
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_timer_irq
);

   localparam int AW = $clog2(MEM_WORDS);

   state_t       state, state_next;
   logic [3:0]   cnt, cnt_next;
   logic         access;
   logic         timer_sel;
   logic         cmp_sel;
   logic         timer_we;
   logic [AW-1:0] idx;
   logic [31:0]  ram_rdt;
   logic [31:0]  timer_rdt;
   logic [31:0]  mem [MEM_WORDS];
   logic         unused_adr;

   assign timer_sel  = i_wb_adr[REGION_BIT];
   assign cmp_sel    = (i_wb_adr[2:0] & MTIMECMP_OFS) != MTIME_OFS;
   assign idx        = i_wb_adr[AW+1:2];
   assign unused_adr = ^i_wb_adr[30:AW+2];

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         IDLE: begin
            if (i_wb_cyc) begin
               cnt_next   = 4'(WAIT_CYCLES);
               state_next = (WAIT_CYCLES != 0) ? WAIT : ACK;
            end
         end
         WAIT: begin
            if (!i_wb_cyc) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - 4'd1;
               if (cnt == 4'd1) state_next = ACK;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The access happens on the edge that enters ACK; reset suppresses it.
   assign access   = (state != ACK) && (state_next == ACK) && i_rst_n;
   assign timer_we = access && i_wb_we && timer_sel;
   assign o_wb_ack = (state == ACK);

   // NOTE: the RAM array has no reset; clearing it would forbid block-RAM
   // inference and software must not rely on its power-up contents.
   always_ff @(posedge clk) begin
      if (access && i_wb_we && !timer_sel) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wb_sel[b]) mem[idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
         end
      end
   end

   assign ram_rdt = mem[idx];

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)    o_wb_rdt <= '0;
      else if (access) o_wb_rdt <= i_wb_we ? '0 : (timer_sel ? timer_rdt : ram_rdt);
   end

   serv_dbus_timer #(
      .TIMER_DIV (TIMER_DIV)
   ) u_timer (
      .clk       (clk),
      .i_rst_n   (i_rst_n),
      .i_we      (timer_we),
      .i_cmp_sel (cmp_sel),
      .i_sel     (i_wb_sel),
      .i_dat     (i_wb_dat),
      .o_rdt     (timer_rdt),
      .o_irq     (o_timer_irq)
   );

endmodule

// File: tb/tb_serv_dbus_responder.sv
// Self-checking bench for serv_dbus_responder: directed and random bus
// traffic compared against a word-array / arithmetic-timer reference model.
module tb_serv_dbus_responder;

   localparam int MEM_WORDS   = 64;
   localparam int WAIT_CYCLES = 2;
   localparam int TIMER_DIV   = 3;
   localparam int AW          = $clog2(MEM_WORDS);
   localparam int BUDGET      = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wb_adr = '0;
   logic [31:0] wb_dat = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic [31:0] wb_rdt;
   logic        wb_ack;
   logic        timer_irq;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n;

   // Reference model: RAM words, mtimecmp, and mtime as base + ticks since the
   // last mtime write (ticks fall on every TIMER_DIV-th edge after reset).
   logic [31:0] mem_m [MEM_WORDS];
   logic [31:0] cmp_m   = 32'hFFFF_FFFF;
   logic [31:0] mt_base = '0;
   int          mt_w    = 0;

   serv_dbus_responder #(
      .MEM_WORDS   (MEM_WORDS),
      .WAIT_CYCLES (WAIT_CYCLES),
      .TIMER_DIV   (TIMER_DIV)
   ) dut (
      .clk         (clk),
      .i_rst_n     (rst_n),
      .i_wb_adr    (wb_adr),
      .i_wb_dat    (wb_dat),
      .i_wb_sel    (wb_sel),
      .i_wb_we     (wb_we),
      .i_wb_cyc    (wb_cyc),
      .o_wb_rdt    (wb_rdt),
      .o_wb_ack    (wb_ack),
      .o_timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mtime_at(input int e);
      return mt_base + 32'((e / TIMER_DIV) - (mt_w / TIMER_DIV));
   endfunction

   // One request; returns the read data and the edge count of the access edge.
   task automatic xact(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdt, output int w);
      int lat = 0;
      if (wb_ack) @(posedge clk);
      @(negedge clk);
      wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
      for (int k = 1; k <= BUDGET; k++) begin
         @(posedge clk); #1;
         if (wb_ack) begin
            lat = k;
            break;
         end
      end
      wb_cyc = 1'b0;
      check("latency", 32'(lat), 32'(WAIT_CYCLES + 1));
      if (we) check("wr_rdt_zero", wb_rdt, 32'h0);
      rdt = wb_rdt;
      w   = edge_n;
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] r;
      int w;
      xact(1'b1, adr, dat, sel, r, w);
      if (adr[31]) begin
         if (adr[2]) cmp_m = merge(cmp_m, dat, sel);
         else begin
            mt_base = merge(mtime_at(w - 1), dat, sel);
            mt_w    = w;
         end
      end else begin
         mem_m[adr[AW+1:2]] = merge(mem_m[adr[AW+1:2]], dat, sel);
      end
   endtask

   task automatic rd(input logic [31:0] adr, input string tag);
      logic [31:0] r, exp;
      int w;
      xact(1'b0, adr, $urandom(), 4'($urandom_range(0, 15)), r, w);
      if (adr[31]) exp = adr[2] ? cmp_m : mtime_at(w - 1);
      else         exp = mem_m[adr[AW+1:2]];
      check(tag, r, exp);
   endtask

   task automatic watch_irq(input int n, output int seen_hi);
      seen_hi = 0;
      repeat (n) begin
         @(posedge clk); #1;
         check("irq", 32'(timer_irq), 32'(mtime_at(edge_n - 1) >= cmp_m));
         if (timer_irq) seen_hi = 1;
      end
   endtask

   initial begin
      logic [31:0] a, d, c;
      int seen, k, last, acks;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(wb_ack), 32'h0);
      check("rst_rdt", wb_rdt, 32'h0);
      check("rst_irq", 32'(timer_irq), 32'h0);
      rst_n = 1'b1;
      rd(32'h8000_0004, "rst_mtimecmp");
      rd(32'h8000_0000, "rst_mtime");

      for (int i = 0; i < MEM_WORDS; i++) wr(32'(i * 4), $urandom(), 4'hF);

      // Byte-lane merge, aliasing and an empty byte mask.
      wr(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
      wr(32'h0000_0100, 32'h0000_00AA, 4'h1);
      rd(32'h0000_0100, "ram_merge");
      wr(32'h0000_1014, 32'h1234_5678, 4'hF);
      rd(32'h0000_0014, "ram_alias");
      wr(32'h0000_0040, 32'hFFFF_FFFF, 4'h0);
      rd(32'h0000_0040, "ram_sel0");

      // Back-to-back reads with cyc held high.
      if (wb_ack) @(posedge clk);
      @(negedge clk);
      wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0014; wb_sel = 4'h0;
      k = 0; last = 0; acks = 0;
      while (acks < 3 && k < 3 * BUDGET) begin
         @(posedge clk); #1;
         k++;
         if (wb_ack) begin
            check("burst_gap", 32'(k - last), 32'(acks == 0 ? WAIT_CYCLES + 1 : WAIT_CYCLES + 2));
            check("burst_rdt", wb_rdt, mem_m[5]);
            last = k;
            acks++;
            if (acks == 3) wb_cyc = 1'b0;
         end
      end
      wb_cyc = 1'b0;
      check("burst_acks", 32'(acks), 32'd3);

      // Random traffic over both regions.
      for (int i = 0; i < 80; i++) begin
         int r;
         r = $urandom_range(0, 9);
         a = $urandom();
         d = $urandom();
         if (r < 4)       wr(a & 32'h7FFF_FFFF, d, 4'($urandom_range(0, 15)));
         else if (r < 8)  rd(a & 32'h7FFF_FFFF, "rand_ram_rd");
         else if (r == 8) rd(a | 32'h8000_0000, "rand_timer_rd");
         else             wr(a | 32'h8000_0000, d, 4'($urandom_range(0, 15)));
      end

      // Abort: cyc dropped in cycle 2 of a write.
      if (wb_ack) @(posedge clk);
      @(negedge clk);
      wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 32'h0000_0008; wb_dat = 32'h55; wb_sel = 4'hF;
      seen = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (wb_ack) seen = 1;
      end
      @(negedge clk);
      wb_cyc = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (wb_ack) seen = 1;
      end
      check("abort_no_ack", 32'(seen), 32'h0);
      rd(32'h0000_0008, "abort_rd");

      // Timer interrupt rise and fall.
      wr(32'h8000_0004, 32'h0, 4'hF);
      wr(32'h8000_0000, 32'd5, 4'hF);
      c = mtime_at(edge_n) + 32'd6;
      wr(32'h8000_0004, c, 4'hF);
      watch_irq(40, seen);
      check("irq_rose", 32'(seen), 32'h1);
      wr(32'h8000_0004, 32'hFFFF_FFFF, 4'hF);
      watch_irq(4, seen);
      wr(32'h8000_000C, 32'h0000_0012, 4'h1);
      rd(32'h8000_0004, "cmp_bytelane");
      wr(32'h8000_0004, 32'hFFFF_FFFF, 4'hF);

      // mtime write on an increment edge, then wrap.
      @(posedge clk); #1;
      while (((edge_n + WAIT_CYCLES + 1) % TIMER_DIV) != 0) begin
         @(posedge clk); #1;
      end
      wr(32'h8000_0000, 32'hFFFF_FFFE, 4'hF);
      rd(32'h8000_0000, "mtime_collision");
      repeat (2 * TIMER_DIV) @(posedge clk);
      rd(32'h8000_0000, "mtime_wrap");

      // Reset during WAIT of a write.
      wr(32'h0000_0020, 32'h1357_2468, 4'hF);
      wr(32'h8000_0004, 32'h0, 4'hF);
      watch_irq(2, seen);
      rd(32'h0000_0020, "pre_rst_rd");
      if (wb_ack) @(posedge clk);
      @(negedge clk);
      wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 32'h0000_0020; wb_dat = 32'hCAFE_F00D; wb_sel = 4'hF;
      @(posedge clk); #1;
      check("rst_wait_noack", 32'(wb_ack), 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      wb_cyc = 1'b0;
      #1;
      check("midrst_ack", 32'(wb_ack), 32'h0);
      check("midrst_rdt", wb_rdt, 32'h0);
      check("midrst_irq", 32'(timer_irq), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mt_base = '0;
      mt_w    = 0;
      cmp_m   = 32'hFFFF_FFFF;
      rd(32'h0000_0020, "midrst_ram");
      rd(32'h8000_0004, "midrst_mtimecmp");
      rd(32'h8000_0000, "midrst_mtime");
      watch_irq(3, seen);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
